// File: rtl/rounding_arbiter.sv
// Round-robin arbiter sharing one round-to-nearest-even datapath among
// several arithmetic requesters, with a single registered result stage.
module rounding_arbiter #(
    parameter int unsigned EXPONENT_WIDTH   = 8,
    parameter int unsigned MANTISSA_WIDTH   = 23,
    parameter int unsigned ROUNDING_BITS    = 3,
    parameter bit          ROUND_TO_NEAREST = 1'b1,
    parameter int unsigned NUM_REQUESTERS   = 2,
    parameter int unsigned ID_WIDTH         = $clog2(NUM_REQUESTERS)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_REQUESTERS-1:0]                 req_valid,
    output logic [NUM_REQUESTERS-1:0]                 req_ready,
    input  logic [NUM_REQUESTERS*EXPONENT_WIDTH-1:0]  req_exponent,
    input  logic [NUM_REQUESTERS*MANTISSA_WIDTH-1:0]  req_mantissa,
    input  logic [NUM_REQUESTERS*ROUNDING_BITS-1:0]   req_rounding_bits,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [EXPONENT_WIDTH-1:0]                 out_exponent,
    output logic [MANTISSA_WIDTH-1:0]                 out_mantissa,
    output logic                                      out_overflow,
    output logic [ID_WIDTH-1:0]                       out_id,
    output logic [15:0]                               overflow_count
);

    localparam int unsigned MANT_EXT_W = MANTISSA_WIDTH + 1;
    localparam int unsigned CNT_W      = 16;
    localparam logic [ROUNDING_BITS-1:0] HALF_GUARD =
        ROUNDING_BITS'(1) << (ROUNDING_BITS - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQUESTERS - 1);

    logic [ID_WIDTH-1:0]       rr_ptr;
    logic                      stage_free_c;
    logic                      grant_found_c;
    logic [ID_WIDTH-1:0]       grant_id_c;
    logic                      accept_c;
    logic                      hi_found_c;
    logic                      lo_found_c;
    logic [ID_WIDTH-1:0]       hi_id_c;
    logic [ID_WIDTH-1:0]       lo_id_c;
    logic [EXPONENT_WIDTH-1:0] exp_sel_c;
    logic [MANTISSA_WIDTH-1:0] mant_sel_c;
    logic [ROUNDING_BITS-1:0]  guard_sel_c;
    logic                      halfway_c;
    logic                      round_up_c;
    logic [MANT_EXT_W-1:0]     mant_sum_c;
    logic [EXPONENT_WIDTH-1:0] rnd_exp_c;
    logic [MANTISSA_WIDTH-1:0] rnd_mant_c;
    logic                      rnd_ovf_c;

    assign stage_free_c = !out_valid || out_ready;

    // Rotating priority: lowest valid index at or above rr_ptr, else lowest below it.
    always_comb begin
        hi_found_c = 1'b0;
        lo_found_c = 1'b0;
        hi_id_c    = '0;
        lo_id_c    = '0;
        for (int i = int'(NUM_REQUESTERS) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (ID_WIDTH'(i) >= rr_ptr) begin
                    hi_found_c = 1'b1;
                    hi_id_c    = ID_WIDTH'(i);
                end else begin
                    lo_found_c = 1'b1;
                    lo_id_c    = ID_WIDTH'(i);
                end
            end
        end
        grant_found_c = hi_found_c || lo_found_c;
        grant_id_c    = hi_found_c ? hi_id_c : lo_id_c;
    end

    assign accept_c = rst_n && grant_found_c && stage_free_c;

    // One-hot ready to the granted requester only when the stage can take it.
    always_comb begin
        req_ready = '0;
        if (accept_c) begin
            req_ready[grant_id_c] = 1'b1;
        end
    end

    // Route the granted requester's operand slices into the rounder.
    always_comb begin
        exp_sel_c   = '0;
        mant_sel_c  = '0;
        guard_sel_c = '0;
        for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
            if (grant_id_c == ID_WIDTH'(i)) begin
                exp_sel_c   = req_exponent[i*EXPONENT_WIDTH +: EXPONENT_WIDTH];
                mant_sel_c  = req_mantissa[i*MANTISSA_WIDTH +: MANTISSA_WIDTH];
                guard_sel_c = req_rounding_bits[i*ROUNDING_BITS +: ROUNDING_BITS];
            end
        end
    end

    // Round to nearest, ties to even; a mantissa carry bumps the exponent and
    // an exponent reaching all-ones saturates to infinity.
    always_comb begin
        halfway_c  = (guard_sel_c == HALF_GUARD);
        round_up_c = ROUND_TO_NEAREST &&
                     ((halfway_c && mant_sel_c[0]) ||
                      (!halfway_c && guard_sel_c[ROUNDING_BITS-1]));
        mant_sum_c = {1'b0, mant_sel_c} + MANT_EXT_W'(1);
        rnd_exp_c  = exp_sel_c;
        rnd_mant_c = mant_sel_c;
        rnd_ovf_c  = 1'b0;
        if (round_up_c) begin
            rnd_mant_c = mant_sum_c[MANTISSA_WIDTH-1:0];
            if (mant_sum_c[MANTISSA_WIDTH]) begin
                rnd_exp_c = exp_sel_c + EXPONENT_WIDTH'(1);
                if (&rnd_exp_c) begin
                    rnd_mant_c = '0;
                    rnd_ovf_c  = 1'b1;
                end
            end
        end
    end

    // Result stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_exponent <= '0;
            out_mantissa <= '0;
            out_overflow <= 1'b0;
            out_id       <= '0;
            rr_ptr       <= '0;
        end else if (accept_c) begin
            out_valid    <= 1'b1;
            out_exponent <= rnd_exp_c;
            out_mantissa <= rnd_mant_c;
            out_overflow <= rnd_ovf_c;
            out_id       <= grant_id_c;
            rr_ptr       <= (grant_id_c == LAST_ID) ? '0 : grant_id_c + ID_WIDTH'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of overflowed results handed downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_count <= '0;
        end else if (out_valid && out_ready && out_overflow && !(&overflow_count)) begin
            overflow_count <= overflow_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/rounding_arbiter.md
# rounding_arbiter

Shares one `result_rounder` datapath among `NUM_REQUESTERS` arithmetic units (adder, multiplier, etc.) that each produce an unrounded exponent, mantissa and guard bits. A round-robin arbiter grants one requester per cycle through a valid/ready handshake. The block rounds the granted operand and holds the result in a single registered output stage, tagged with the requester ID. It sits between the arithmetic cores and the result writeback/packing logic.

## Interface
- `EXPONENT_WIDTH`, 8: exponent field width.
- `MANTISSA_WIDTH`, 23: stored mantissa width.
- `ROUNDING_BITS`, 3: guard bits per request; must be at least 2.
- `ROUND_TO_NEAREST`, 1: 1 selects round-to-nearest-even, 0 selects truncate.
- `NUM_REQUESTERS`, 2: number of requesters, 2..8.
- `ID_WIDTH`, `$clog2(NUM_REQUESTERS)`: requester ID width.
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  NUM_REQUESTERS  per-requester request valid.
- `req_ready`  out  NUM_REQUESTERS  per-requester accept; one-hot or zero.
- `req_exponent`  in  NUM_REQUESTERS*EXPONENT_WIDTH  flattened; requester i occupies slice [i*EXPONENT_WIDTH +: EXPONENT_WIDTH].
- `req_mantissa`  in  NUM_REQUESTERS*MANTISSA_WIDTH  flattened, same slicing.
- `req_rounding_bits`  in  NUM_REQUESTERS*ROUNDING_BITS  flattened, same slicing.
- `out_valid`  out  1  result stage holds a valid result.
- `out_ready`  in  1  downstream accepts the result.
- `out_exponent`  out  EXPONENT_WIDTH  rounded exponent.
- `out_mantissa`  out  MANTISSA_WIDTH  rounded mantissa.
- `out_overflow`  out  1  rounding overflowed to infinity.
- `out_id`  out  ID_WIDTH  index of the requester that produced this result.
- `overflow_count`  out  16  saturating count of overflowed results delivered.

## Operation
- Stage free: `stage_free = !out_valid || out_ready`.
- Arbitration:
  - Round-robin pointer `rr_ptr` (ID_WIDTH bits).
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQUESTERS.
  - The first requester with req_valid set is granted.
  - `req_ready[g] = grant[g] && stage_free`; all other bits are 0.
- Accept: occurs when `req_valid[g] && req_ready[g]`. On accept, set `rr_ptr <= (g+1) mod NUM_REQUESTERS`. With no accept, rr_ptr holds.
- Rounding (combinational on the granted slice; ROUND_TO_NEAREST=1):
  - halfway = (guard == 1 followed by zeros).
  - Round up when (halfway && mantissa[0]) or (!halfway && guard MSB == 1).
  - Round up means mantissa + 1. If the mantissa wraps to 0, exponent + 1.
  - If that exponent equals all-ones, force mantissa to 0 and set overflow.
  - ROUND_TO_NEAREST=0: pass exponent and mantissa through unchanged; overflow is 0.
- Output stage:
  - On accept, load out_exponent, out_mantissa, out_overflow and out_id (=g), and set out_valid.
  - If `out_valid && out_ready` and there is no new accept, clear out_valid.
  - Simultaneous drain and accept: the new result replaces the old one; out_valid stays 1.
- Stability: while `out_valid && !out_ready`, all out_* fields hold stable and req_ready is all zeros.
- overflow_count: increments on `out_valid && out_ready && out_overflow`, saturating at 0xFFFF.
- Input rule: req_valid must not depend combinationally on req_ready. A requester keeps valid and data stable until it is accepted.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_exponent=0, out_mantissa=0, out_overflow=0, out_id=0, overflow_count=0, rr_ptr=0.
  - req_ready=0 while rst_n is low.
- Reset asserted mid-transfer discards the held result and any in-flight accept. Nothing is delivered after reset releases.
- Latency: 1 cycle. A request accepted at edge k yields out_valid=1 after edge k.
- Throughput: 1 result/cycle while out_ready=1.
- Under full contention each requester gets 1 of every NUM_REQUESTERS accepts. There is no starvation.
- No combinational path from req_* to out_*. req_ready depends combinationally on req_valid, out_valid, out_ready and rr_ptr.

## Test plan
- **Reset:** assert rst_n=0 mid-stream with out_valid=1 → out_valid=0, overflow_count=0 immediately. After release with only req_valid=2'b10 → req_ready=2'b10 and out_id=1 one cycle later.
- **Ties-to-even:** exp 0x80, mant 0x000001, guard 3'b100 → out 0x80/0x000002. Mant 0x000002, guard 3'b100 → 0x000002. Guard 3'b011 → unchanged. Guard 3'b101 on 0x000002 → 0x000003.
- **Carry and overflow:**
  - exp 0x80, mant 0x7FFFFF, guard 3'b110 → exp 0x81, mant 0, out_overflow=0.
  - exp 0xFE, mant 0x7FFFFF, guard 3'b101 → exp 0xFF, mant 0, out_overflow=1; overflow_count=1 after the handshake.
- **Contention:** both req_valid held high, out_ready=1, 6 cycles → out_id sequence 0,1,0,1,0,1 on consecutive cycles; data matches the corresponding slice.
- **Backpressure:** out_ready=0 for 3 cycles with out_valid=1 → out_* stable and req_ready=0. On release, results drain in order with no loss or duplication; each requester's data is seen exactly once.
- **Truncate mode (ROUND_TO_NEAREST=0):** mant 0x7FFFFF, guard 3'b111 → mant 0x7FFFFF, exp unchanged, overflow 0.
